icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the datapath fetch port and the memory controller's instruction channel.
- Serves hits combinationally in the same cycle.
- On a miss, fills a 2-word block through the controller's iREN/iaddr/iload/iwait handshake: word 0 first, then word 1.
- Stalls the datapath by holding ihit low until the fill completes.

Parameters:
- SETS, 8, number of frames; power of two, ≥2.
- Derived widths: IDXW = log2(SETS); TAGW = 32 - 3 - IDXW.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- imemREN  in  1  datapath instruction read request
- imemaddr  in  32  datapath fetch byte address
- ihit  out  1  instruction valid this cycle; datapath advances PC
- imemload  out  32  instruction word returned to datapath
- iREN  out  1  read request to memory controller
- iaddr  out  32  word address to memory controller
- iwait  in  1  memory controller busy; 0 = iload valid this cycle
- iload  in  32  word returned by memory controller

Behaviour:
- Address split: [1:0] byte offset, ignored; [2] block offset (word select); [2+IDXW:3] index; [31:3+IDXW] tag.
- Storage per frame: valid bit, TAGW-bit tag, two 32-bit words.
- FSM states: IDLE, FETCH0, FETCH1.
- Reset (async, nRST=0):
  - all valid bits 0; state IDLE.
  - miss tag/index registers 0.
  - outputs ihit=0, iREN=0, iaddr=0, imemload=0.
  - tag/data arrays need not be cleared.
- Hit (combinational):
  - hit = imemREN & state==IDLE & valid[idx] & tag[idx]==addr tag.
  - ihit = hit.
  - imemload = data[idx][addr[2]] when hit, else 0.
- IDLE:
  - imemREN & !hit -> latch addr tag and index into miss registers; next state FETCH0.
  - imemREN=0 -> stay; iREN=0, iaddr=0.
- FETCH0:
  - iREN=1; iaddr = {missTag, missIdx, 1'b0, 2'b00}; ihit=0.
  - iwait=0 -> data[missIdx][0] <= iload; valid[missIdx] <= 0; next state FETCH1.
  - iwait=1 -> hold state and outputs.
- FETCH1:
  - iREN=1; iaddr = {missTag, missIdx, 1'b1, 2'b00}; ihit=0.
  - iwait=0 -> data[missIdx][1] <= iload; tag[missIdx] <= missTag; valid[missIdx] <= 1; next state IDLE.
- Miss latency: with iwait low on first FETCH cycle = 2 fill cycles + 1 hit cycle. General = cycles(FETCH0) + cycles(FETCH1) + 1.
- iREN is asserted from the first FETCH0 cycle. The controller may drop iwait combinationally in that same cycle.
- Fill address comes from the miss registers, not imemaddr. Changes to imemaddr or deassertion of imemREN mid-fill do not abort or redirect the fill; the fill always completes.
- Replacement: a miss unconditionally evicts the resident block of that index. No write-back (read-only).
- A frame's valid bit is set only at FETCH1 completion. Reset mid-fill leaves that frame invalid, with no partial block visible.
- Back-to-back: a hit in IDLE makes no state change. The next fetch can hit or miss in the following cycle.
- Tag compare uses the full TAGW bits. Address 0xFFFFFFFC is legal (tag all ones, block offset 1).

Test Plan:
- Cold miss:
  - Stimulus: reset; imemREN=1, imemaddr=0x00000004; memory returns 0x11111111 @0x0 and 0x22222222 @0x4, iwait low 1 cycle after each request.
  - Required: iaddr 0x0 then 0x4; ihit=0 through fill; next cycle ihit=1, imemload=0x22222222.
- Spatial hit:
  - Stimulus: after the cold miss, imemaddr=0x00000000.
  - Required: ihit=1 same cycle, imemload=0x11111111, iREN=0.
- Conflict eviction:
  - Stimulus: fill 0x00000000, then fetch 0x00000040 (same index 0, tag 1), then 0x00000000 again.
  - Required: each access misses with a 2-word fill; 0x00000040 returns its own data.
- Address change mid-fill:
  - Stimulus: miss on 0x00000100; during FETCH0 (iwait=1 for 3 cycles) change imemaddr to 0x00000200 and drop imemREN.
  - Required: iaddr stays 0x100/0x104; frame for 0x100 is valid afterwards.
- Reset mid-fill:
  - Stimulus: assert nRST=0 while in FETCH1 for 0x00000080.
  - Required: outputs go 0 immediately; after release, fetch of 0x80 misses again.
- Byte-offset ignore and top address:
  - Stimulus: fetch 0xFFFFFFFF after fill of 0xFFFFFFF8.
  - Required: hit, returns the word at 0xFFFFFFFC.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with 2-word blocks.
// Hits are served combinationally in IDLE. A miss fills word 0 and then
// word 1 over the iREN/iaddr/iload/iwait handshake. The frame only becomes
// valid once the whole block has arrived.
//
// state  | meaning
// IDLE   | serving hits; a miss latches tag/index and starts a fill
// FETCH0 | requesting word 0 of the missed block
// FETCH1 | requesting word 1; tag written and frame validated on completion
module icache_direct #(
  parameter int SETS = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 32 - 3 - IDXW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2
  } state_t;

  state_t          state_q;
  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q   [SETS];
  logic [31:0]     data0_q [SETS];
  logic [31:0]     data1_q [SETS];
  logic [TAGW-1:0] miss_tag_q;
  logic [IDXW-1:0] miss_idx_q;
  logic            iren_q;
  logic [31:0]     iaddr_q;

  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] req_tag;
  logic            req_word;
  logic            hit;
  logic            unused_byte_offset;

  assign req_idx            = imemaddr[2+IDXW:3];
  assign req_tag            = imemaddr[31:3+IDXW];
  assign req_word           = imemaddr[2];
  assign unused_byte_offset = ^imemaddr[1:0];

  // Hit detection and read mux; the datapath sees the word in the same cycle.
  always_comb begin
    hit      = imemREN && (state_q == IDLE) && valid_q[req_idx]
               && (tag_q[req_idx] == req_tag);
    imemload = '0;
    if (hit) begin
      imemload = req_word ? data1_q[req_idx] : data0_q[req_idx];
    end
  end

  assign ihit  = hit;
  assign iREN  = iren_q;
  assign iaddr = iaddr_q;

  // Fill sequencer: miss registers, valid bits and the registered request
  // outputs. The fill address comes only from the miss registers, so the
  // datapath changing its fetch address mid-fill cannot redirect it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      iren_q     <= 1'b0;
      iaddr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (imemREN && !hit) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
            iren_q     <= 1'b1;
            iaddr_q    <= {req_tag, req_idx, 3'b000};
            state_q    <= FETCH0;
          end
        end
        FETCH0: begin
          if (!iwait) begin
            valid_q[miss_idx_q] <= 1'b0;
            iaddr_q             <= {miss_tag_q, miss_idx_q, 3'b100};
            state_q             <= FETCH1;
          end
        end
        FETCH1: begin
          if (!iwait) begin
            valid_q[miss_idx_q] <= 1'b1;
            iren_q              <= 1'b0;
            iaddr_q             <= '0;
            state_q             <= IDLE;
          end
        end
        default: begin
          iren_q  <= 1'b0;
          iaddr_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Tag and data storage; no reset needed because valid bits gate every hit.
  always_ff @(posedge CLK) begin
    if (state_q == FETCH0 && !iwait) begin
      data0_q[miss_idx_q] <= iload;
    end
    if (state_q == FETCH1 && !iwait) begin
      data1_q[miss_idx_q] <= iload;
      tag_q[miss_idx_q]   <= miss_tag_q;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed vector table, hand-written mid-fill
// sequences, then randomized fetches against a block-address reference model.
module tb_icache_direct;

  localparam int SETS = 8;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int checks = 0;
  int errors = 0;

  // Reference model: which block (byte address >> 3) each frame holds.
  bit          ref_valid [SETS];
  logic [28:0] ref_block [SETS];

  typedef struct {
    logic [31:0] addr;
    int          w0;
    int          w1;
    bit          hit;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [10];

  icache_direct #(.SETS(SETS)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (wa == 32'h0) return 32'h1111_1111;
    if (wa == 32'h4) return 32'h2222_2222;
    return {wa[15:0], wa[31:16]} ^ 32'h9E37_79B9;
  endfunction

  function automatic int ref_index(input logic [31:0] a);
    return int'((a >> 3) % SETS);
  endfunction

  function automatic bit ref_hit(input logic [31:0] a);
    int i;
    i = ref_index(a);
    return ref_valid[i] && (ref_block[i] == a[31:3]);
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < SETS; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One fetch of address a. On a miss, serves the fill with w0/w1 busy
  // cycles per word, checking the request each cycle, then checks the hit.
  // wander: move imemaddr away and drop imemREN while the fill runs.
  task automatic fetch(input logic [31:0] a, input int w0, input int w1,
                       input bit exp_hit, input logic [31:0] exp_data, input bit wander);
    logic [31:0] blk;
    blk = {a[31:3], 3'b000};
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    iload    = 32'hBAD0_BAD0;
    #1;
    chk($sformatf("ihit_first@%h", a), 32'(ihit), 32'(exp_hit));
    if (exp_hit) begin
      chk($sformatf("load_hit@%h", a), imemload, exp_data);
      chk($sformatf("iren_hit@%h", a), 32'(iREN), 32'd0);
    end else begin
      chk($sformatf("load_miss@%h", a), imemload, 32'h0);
      for (int k = 0; k <= w0; k++) begin
        @(negedge CLK);
        if (wander) begin
          imemREN  = 1'b0;
          imemaddr = 32'h0000_0200;
        end
        iwait = (k < w0);
        iload = iwait ? 32'hBAD0_BAD0 : mem_word(blk);
        #1;
        chk($sformatf("iren_f0@%h", a), 32'(iREN), 32'd1);
        chk($sformatf("iaddr_f0@%h", a), iaddr, blk);
        chk($sformatf("ihit_f0@%h", a), 32'(ihit), 32'd0);
      end
      for (int k = 0; k <= w1; k++) begin
        @(negedge CLK);
        iwait = (k < w1);
        iload = iwait ? 32'hBAD0_BAD0 : mem_word(blk | 32'h4);
        #1;
        chk($sformatf("iren_f1@%h", a), 32'(iREN), 32'd1);
        chk($sformatf("iaddr_f1@%h", a), iaddr, blk | 32'h4);
        chk($sformatf("ihit_f1@%h", a), 32'(ihit), 32'd0);
      end
      ref_valid[ref_index(a)] = 1'b1;
      ref_block[ref_index(a)] = a[31:3];
      @(negedge CLK);
      imemREN  = 1'b1;
      imemaddr = a;
      iwait    = 1'b1;
      iload    = 32'hBAD0_BAD0;
      #1;
      chk($sformatf("ihit_after@%h", a), 32'(ihit), 32'd1);
      chk($sformatf("load_after@%h", a), imemload, exp_data);
      chk($sformatf("iren_after@%h", a), 32'(iREN), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    bit          eh;

    vecs[0] = '{32'h0000_0004, 1, 1, 1'b0, 32'h2222_2222};
    vecs[1] = '{32'h0000_0000, 0, 0, 1'b1, 32'h1111_1111};
    vecs[2] = '{32'h0000_0040, 0, 1, 1'b0, mem_word(32'h0000_0040)};
    vecs[3] = '{32'h0000_0000, 2, 0, 1'b0, 32'h1111_1111};
    vecs[4] = '{32'h0000_0004, 0, 0, 1'b1, 32'h2222_2222};
    vecs[5] = '{32'h0000_0044, 0, 0, 1'b0, mem_word(32'h0000_0044)};
    vecs[6] = '{32'hFFFF_FFF8, 1, 2, 1'b0, mem_word(32'hFFFF_FFF8)};
    vecs[7] = '{32'hFFFF_FFFF, 0, 0, 1'b1, mem_word(32'hFFFF_FFFC)};
    vecs[8] = '{32'h0000_0008, 0, 0, 1'b0, mem_word(32'h0000_0008)};
    vecs[9] = '{32'h0000_000E, 0, 0, 1'b1, mem_word(32'h0000_000C)};

    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    ref_clear();
    repeat (3) @(negedge CLK);
    imemREN = 1'b1;
    #1;
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_load", imemload, 32'd0);
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // Directed vectors: cold miss, spatial hit, conflicts, top address.
    for (int v = 0; v < 10; v++) begin
      fetch(vecs[v].addr, vecs[v].w0, vecs[v].w1, vecs[v].hit, vecs[v].data, 1'b0);
    end

    // Address change mid-fill: fill must stay on 0x100 and validate it.
    fetch(32'h0000_0100, 3, 1, 1'b0, mem_word(32'h0000_0100), 1'b1);
    fetch(32'h0000_0104, 0, 0, 1'b1, mem_word(32'h0000_0104), 1'b0);

    // Reset during FETCH1 of 0x80.
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h0000_0080; iwait = 1'b1;
    #1;
    chk("rstfill_miss", 32'(ihit), 32'd0);
    @(negedge CLK);
    iwait = 1'b0; iload = mem_word(32'h0000_0080);
    #1;
    chk("rstfill_iaddr0", iaddr, 32'h0000_0080);
    @(negedge CLK);
    iwait = 1'b1; iload = 32'hBAD0_BAD0;
    #1;
    chk("rstfill_iaddr1", iaddr, 32'h0000_0084);
    #1;
    nRST = 1'b0;
    #1;
    chk("rstfill_iren", 32'(iREN), 32'd0);
    chk("rstfill_iaddr", iaddr, 32'd0);
    chk("rstfill_ihit", 32'(ihit), 32'd0);
    chk("rstfill_load", imemload, 32'd0);
    ref_clear();
    @(negedge CLK);
    nRST = 1'b1;
    fetch(32'h0000_0080, 0, 0, 1'b0, mem_word(32'h0000_0080), 1'b0);
    fetch(32'h0000_0004, 0, 0, 1'b0, 32'h2222_2222, 1'b0);

    // Randomized fetches over a small tag pool so hits and conflicts recur.
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0:       a[31:6] = '0;
        1:       a[31:6] = 26'd1;
        default: a[31:6] = '1;
      endcase
      eh = ref_hit(a);
      fetch(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), eh,
            mem_word({a[31:2], 2'b00}), ($urandom_range(0, 3) == 0));
    end

    @(negedge CLK);
    imemREN = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
